// File: rtl/control_seq.sv
// control_seq: multi-cycle instruction control FSM with multiply/divide wait and exception sequencing
module control_seq #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       overflow_i,
    input  logic       div0_i,
    input  logic       md_done_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_wr_o,
    output logic       reg_write_o,
    output logic       aluout_write_o,
    output logic       epc_write_o,
    output logic       hilo_write_o,
    output logic       md_start_o,
    output logic       md_sel_o,
    output logic [2:0] pc_src_o,
    output logic [2:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [2:0] wb_sel_o,
    output logic [2:0] mem_addr_sel_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] exc_cause_o,
    output logic       md_timeout_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_WB, S_MDW, S_EXC, S_EXCJ} state_e;
    typedef enum logic [3:0] {C_ADD, C_SUB, C_AND, C_MULT, C_DIV, C_MFHI, C_MFLO, C_JR, C_INV} cls_e;
    // Last wait cycle: the counter reaches MD_TIMEOUT with this cycle's increment
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, cls_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             tmo_q, tmo_d;
    logic             div_err;
    // Instruction class decode; only opcode 0 carries supported ops
    always_comb begin
        cls_dec = C_INV;
        if (opcode_i == 6'd0)
            case (funct_i)
                6'h20:   cls_dec = C_ADD;
                6'h22:   cls_dec = C_SUB;
                6'h24:   cls_dec = C_AND;
                6'h18:   cls_dec = C_MULT;
                6'h1A:   cls_dec = C_DIV;
                6'h10:   cls_dec = C_MFHI;
                6'h12:   cls_dec = C_MFLO;
                6'h08:   cls_dec = C_JR;
                default: cls_dec = C_INV;
            endcase
    end
    assign div_err = md_done_i && (cls_q == C_DIV) && div0_i;
    // State and bookkeeping registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RST;
            cls_q   <= C_INV;
            cnt_q   <= '0;
            cause_q <= 2'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            tmo_q   <= tmo_d;
        end
    end
    // Next state, op-class latch, wait counter and exception cause update
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cls_d   = cls_dec;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_ADD, C_SUB: begin
                        state_d = overflow_i ? S_EXC : S_WB;
                        cause_d = overflow_i ? 2'd2 : cause_q;
                    end
                    C_AND:         state_d = S_WB;
                    C_MULT, C_DIV: begin
                        cnt_d   = '0;
                        state_d = S_MDW;
                    end
                    C_INV: begin
                        cause_d = 2'd1;
                        state_d = S_EXC;
                    end
                    default:       state_d = S_FETCH;
                endcase
            end
            S_WB:     state_d = S_FETCH;
            S_MDW: begin
                cnt_d = cnt_q + 1'b1;
                if (md_done_i) begin
                    state_d = div_err ? S_EXC : S_FETCH;
                    cause_d = div_err ? 2'd3 : cause_q;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXC:    state_d = S_EXCJ;
            S_EXCJ:   state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end
    // Moore output decode from state and latched class; hilo_write also qualified by md_done
    always_comb begin
        pc_write_o     = 1'b0;
        ir_write_o     = 1'b0;
        mem_wr_o       = 1'b0;
        reg_write_o    = 1'b0;
        aluout_write_o = 1'b0;
        epc_write_o    = 1'b0;
        hilo_write_o   = 1'b0;
        md_start_o     = 1'b0;
        md_sel_o       = 1'b0;
        pc_src_o       = 3'd0;
        alu_src_b_o    = 3'd0;
        alu_op_o       = 3'd0;
        wb_sel_o       = 3'd0;
        mem_addr_sel_o = 3'd0;
        alu_src_a_o    = 2'd0;
        reg_dst_o      = 2'd0;
        case (state_q)
            S_FETCH: begin
                pc_write_o  = 1'b1;
                ir_write_o  = 1'b1;
                alu_src_b_o = 3'd2;
                alu_op_o    = 3'd1;
            end
            S_DECODE: begin
                alu_src_b_o    = 3'd4;
                alu_op_o       = 3'd1;
                aluout_write_o = 1'b1;
            end
            S_EXEC: begin
                case (cls_q)
                    C_ADD, C_SUB, C_AND: begin
                        alu_src_a_o    = 2'd2;
                        alu_op_o       = (cls_q == C_ADD) ? 3'd1 : (cls_q == C_SUB) ? 3'd2 : 3'd3;
                        aluout_write_o = 1'b1;
                    end
                    C_MFHI, C_MFLO: begin
                        reg_write_o = 1'b1;
                        wb_sel_o    = (cls_q == C_MFHI) ? 3'd2 : 3'd3;
                    end
                    C_JR: begin
                        alu_src_a_o = 2'd2;
                        pc_write_o  = 1'b1;
                    end
                    C_MULT, C_DIV: begin
                        md_start_o = 1'b1;
                        md_sel_o   = (cls_q == C_DIV);
                    end
                    default: ;
                endcase
            end
            S_WB:    reg_write_o = 1'b1;
            S_MDW: begin
                md_sel_o     = (cls_q == C_DIV);
                hilo_write_o = md_done_i && !div_err;
            end
            S_EXC: begin
                epc_write_o    = 1'b1;
                alu_src_b_o    = 3'd2;
                alu_op_o       = 3'd2;
                mem_addr_sel_o = 3'd4 + {1'b0, cause_q};
            end
            S_EXCJ: begin
                pc_src_o   = 3'd6;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end
    assign exc_cause_o  = cause_q;
    assign md_timeout_o = tmo_q;
    assign state_o      = state_q;
endmodule
